alu_md: RTL and testbench
=========================

// Module: alu_md
// PURPOSE
//  Parametrised sequential successor of the datapath ALU: all single-cycle MIPS ALU ops plus an
//  iterative multiply/divide unit with architectural HI/LO registers. Sits in EX stage; the
//  pipeline stalls on in_ready=0. Results are registered; every op completes with an out_valid pulse.
// PARAMETERS
//  WIDTH    32             datapath width (>=8, power of 2)
//  SHAMT_W  $clog2(WIDTH)  shift-amount width
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        op request; accepted when in_valid & in_ready
//  in_ready   out  1        1 = can accept a new op (IDLE)
//  aluop      in   5        operation code (alu_md_pkg)
//  a, b       in   WIDTH    operands (a = rs, b = rt/imm)
//  s          in   SHAMT_W  immediate shift amount
//  out_valid  out  1        1-cycle pulse: aluout/hi/lo updated
//  aluout     out  WIDTH    registered result; holds until the next completion
//  hi, lo     out  WIDTH    architectural HI/LO
//  dbz        out  1        sticky to next accept: last DIV/DIVU had b==0
// BEHAVIOUR
//  Reset: aluout=0, hi=0, lo=0, out_valid=0, dbz=0, in_ready=1, FSM=IDLE. Async assert aborts any op.
//  Single-cycle ops (ADD SUB OR SLT SLL SRL SRA SLLV SRLV SRAV AND XOR NOR PASSA SLTU, MFHI MFLO
//   MTHI MTLO): accepted at edge N; aluout (or hi/lo) + out_valid=1 at edge N+1; in_ready stays 1.
//  ADD/SUB: modulo 2^WIDTH, no overflow trap. SLT signed, SLTU unsigned; result 0 or 1, zero-extended.
//  Shifts: SLL/SRL/SRA use s; *V variants use a[SHAMT_W-1:0]. SRA = arithmetic >>>; shift 0 returns b.
//  MTHI/MTLO: hi<=a / lo<=a, aluout unchanged. MFHI/MFLO: aluout<=hi / lo.
//  Undefined aluop: aluout<=0, out_valid still pulses.
//  MULT/MULTU/DIV/DIVU: FSM IDLE -> MUL|DIV -> DONE -> IDLE.
//   - Accept at edge N: latch |a|,|b| (signed ops) and result-sign bits; in_ready=0 from N+1.
//   - MUL: radix-2 shift-add, 1 bit/cycle, WIDTH iterations. DIV: restoring, 1 quotient bit/cycle.
//   - DONE: apply sign fix, write {hi,lo}; out_valid=1 at edge N+WIDTH+1; in_ready=1 same cycle.
//   - MULT{U}: {hi,lo} = full 2*WIDTH product. DIV{U}: lo=quotient, hi=remainder;
//     signed: quotient truncates toward zero, remainder takes sign of a.
//   - DIV -2^(W-1)/-1: lo=-2^(W-1), hi=0 (wraps, no trap).
//   - b==0: skip iterations, DONE at edge N+2: lo=all ones, hi=a, dbz=1.
//   - aluout unchanged by mul/div ops.
//  in_valid while in_ready=0: ignored, not queued (pipeline must hold request).
//  New op accepted in DONE cycle is not allowed (in_ready=1 only from IDLE after DONE edge).
//  Reset mid-MUL/DIV: hi/lo=0, no out_valid, FSM=IDLE.
// STRUCTURE
//  alu_md_pkg: aluop localparams (0x00-0x0E as existing ALU codes, 0x10 MULT, 0x11 MULTU,
//   0x12 DIV, 0x13 DIVU, 0x14 MFHI, 0x15 MFLO, 0x16 MTHI, 0x17 MTLO), FSM state encoding.
//  Sub-module md_iter: shared iterative datapath (acc/quotient, remainder, counter, mode bit),
//   start/done handshake; top holds single-cycle ALU, HI/LO, FSM and sign fix-up.
// TESTING
//  1 SRA b=0x8000_0000, s=4 -> aluout=0xF800_0000; s=0 -> 0x8000_0000; out_valid 1 cycle after accept.
//  2 SLT a=0xFFFF_FFFF,b=1 -> 1; SLTU same -> 0; undefined aluop 0x1F -> 0 with out_valid.
//  3 MULT a=-3,b=7 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB; MULTU 0xFFFF_FFFF^2 -> hi=0xFFFF_FFFE, lo=1;
//    out_valid exactly 33 cycles after accept; in_ready=0 throughout.
//  4 DIV a=-7,b=2 -> lo=-3, hi=-1; DIVU a=7,b=0 -> lo=0xFFFF_FFFF, hi=7, dbz=1 after 2 cycles.
//  5 in_valid pulsed during busy MUL -> ignored; MTLO 5 then MFLO -> aluout=5.
//  6 async rst at cycle 10 of DIV -> hi=lo=0, no out_valid, in_ready=1; repeat all with WIDTH=16.

Source files
------------

// File: rtl/alu_md_pkg.sv
// Shared opcodes, FSM state type and opcode classification for alu_md.
package alu_md_pkg;

    localparam logic [4:0] OP_ADD   = 5'h00;
    localparam logic [4:0] OP_SUB   = 5'h01;
    localparam logic [4:0] OP_OR    = 5'h02;
    localparam logic [4:0] OP_SLT   = 5'h03;
    localparam logic [4:0] OP_SLL   = 5'h04;
    localparam logic [4:0] OP_SRL   = 5'h05;
    localparam logic [4:0] OP_SRA   = 5'h06;
    localparam logic [4:0] OP_SLLV  = 5'h07;
    localparam logic [4:0] OP_SRLV  = 5'h08;
    localparam logic [4:0] OP_SRAV  = 5'h09;
    localparam logic [4:0] OP_AND   = 5'h0A;
    localparam logic [4:0] OP_XOR   = 5'h0B;
    localparam logic [4:0] OP_NOR   = 5'h0C;
    localparam logic [4:0] OP_PASSA = 5'h0D;
    localparam logic [4:0] OP_SLTU  = 5'h0E;
    localparam logic [4:0] OP_MULT  = 5'h10;
    localparam logic [4:0] OP_MULTU = 5'h11;
    localparam logic [4:0] OP_DIV   = 5'h12;
    localparam logic [4:0] OP_DIVU  = 5'h13;
    localparam logic [4:0] OP_MFHI  = 5'h14;
    localparam logic [4:0] OP_MFLO  = 5'h15;
    localparam logic [4:0] OP_MTHI  = 5'h16;
    localparam logic [4:0] OP_MTLO  = 5'h17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } md_state_t;

    // Multi-cycle ops occupy 0x10..0x13; bit1 selects divide, bit0 selects unsigned.
    function automatic logic is_md_op(input logic [4:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative unsigned datapath: radix-2 shift-add multiply or restoring divide, 1 bit/cycle.
module md_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,      // 0 = multiply, 1 = divide
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,    // product high / remainder
    output logic [WIDTH-1:0] res_lo     // product low / quotient
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc, quo, dvs;
    logic [CW-1:0]    cnt;
    logic             busy, mode_r, last, zdiv;
    logic [WIDTH:0]   sum, shifted, diff;

    assign last   = (cnt == CW'(WIDTH - 1));
    assign zdiv   = mode_r & (dvs == '0);
    assign done   = busy & (last | zdiv);
    assign res_hi = acc;
    assign res_lo = quo;

    // Partial sum for multiply and trial subtraction for divide.
    always_comb begin
        sum     = {1'b0, acc} + {1'b0, dvs};
        shifted = {acc, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
    end

    // Iteration registers; a zero divisor leaves quo holding the dividend untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            quo    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            mode_r <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            quo    <= op_a;
            dvs    <= op_b;
            cnt    <= '0;
            busy   <= 1'b1;
            mode_r <= mode;
        end else if (busy) begin
            if (zdiv) begin
                busy <= 1'b0;
            end else begin
                if (!mode_r) begin
                    if (quo[0]) {acc, quo} <= {sum, quo[WIDTH-1:1]};
                    else        {acc, quo} <= {1'b0, acc, quo[WIDTH-1:1]};
                end else if (!diff[WIDTH]) begin
                    acc <= diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    acc <= shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
                cnt <= cnt + 1'b1;
                if (last) busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU with single-cycle ops plus iterative multiply/divide and HI/LO registers.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         aluop,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] s,
    output logic               out_valid,
    output logic [WIDTH-1:0]   aluout,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               dbz
);
    md_state_t state, state_next;

    logic               accept, md_start, md_mode, md_done;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b, md_hi, md_lo, q_fix, r_fix, alu_res;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic               sgn_q, sgn_r, zdiv, op_mul;
    logic               sc_vld;
    logic [4:0]         sc_op;
    logic [WIDTH-1:0]   sc_a, sc_b;
    logic [SHAMT_W-1:0] sc_s;

    md_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .mode   (md_mode),
        .op_a   (mag_a),
        .op_b   (mag_b),
        .done   (md_done),
        .res_hi (md_hi),
        .res_lo (md_lo)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // FSM next-state: IDLE -> MUL|DIV -> DONE -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (md_start) state_next = md_mode ? ST_DIV : ST_MUL;
            ST_MUL,
            ST_DIV:  if (md_done)  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs and operand magnitude preparation for the iterative unit.
    always_comb begin
        in_ready = (state == ST_IDLE);
        accept   = in_valid & in_ready;
        md_start = accept & is_md_op(aluop);
        md_mode  = aluop[1];
        a_neg    = ~aluop[0] & a[WIDTH-1];
        b_neg    = ~aluop[0] & b[WIDTH-1];
        mag_a    = a_neg ? -a : a;
        mag_b    = b_neg ? -b : b;
    end

    // Sign fix-up of the unsigned iterative results.
    always_comb begin
        prod     = {md_hi, md_lo};
        prod_fix = sgn_q ? -prod : prod;
        q_fix    = sgn_q ? -md_lo : md_lo;
        r_fix    = sgn_r ? -md_hi : md_hi;
    end

    // Single-cycle ops are registered at accept and evaluated one edge later, giving the
    // one-cycle accept-to-result latency while in_ready stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_vld <= 1'b0;
            sc_op  <= '0;
            sc_a   <= '0;
            sc_b   <= '0;
            sc_s   <= '0;
        end else begin
            sc_vld <= accept & ~is_md_op(aluop);
            if (accept & ~is_md_op(aluop)) begin
                sc_op <= aluop;
                sc_a  <= a;
                sc_b  <= b;
                sc_s  <= s;
            end
        end
    end

    // Single-cycle ALU result from the staged operands.
    always_comb begin
        alu_res = '0;
        case (sc_op)
            OP_ADD:   alu_res = sc_a + sc_b;
            OP_SUB:   alu_res = sc_a - sc_b;
            OP_OR:    alu_res = sc_a | sc_b;
            OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(sc_a) < $signed(sc_b)};
            OP_SLL:   alu_res = sc_b << sc_s;
            OP_SRL:   alu_res = sc_b >> sc_s;
            OP_SRA:   alu_res = $signed(sc_b) >>> sc_s;
            OP_SLLV:  alu_res = sc_b << sc_a[SHAMT_W-1:0];
            OP_SRLV:  alu_res = sc_b >> sc_a[SHAMT_W-1:0];
            OP_SRAV:  alu_res = $signed(sc_b) >>> sc_a[SHAMT_W-1:0];
            OP_AND:   alu_res = sc_a & sc_b;
            OP_XOR:   alu_res = sc_a ^ sc_b;
            OP_NOR:   alu_res = ~(sc_a | sc_b);
            OP_PASSA: alu_res = sc_a;
            OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, sc_a < sc_b};
            OP_MFHI:  alu_res = hi;
            OP_MFLO:  alu_res = lo;
            default:  alu_res = '0;
        endcase
    end

    // Architectural results: aluout, HI/LO, completion pulse and divide-by-zero flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aluout    <= '0;
            hi        <= '0;
            lo        <= '0;
            out_valid <= 1'b0;
            dbz       <= 1'b0;
            sgn_q     <= 1'b0;
            sgn_r     <= 1'b0;
            zdiv      <= 1'b0;
            op_mul    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) dbz <= 1'b0;
            if (md_start) begin
                sgn_q  <= a_neg ^ b_neg;
                sgn_r  <= a_neg;
                zdiv   <= md_mode & (b == '0);
                op_mul <= ~md_mode;
            end
            if (sc_vld) begin
                out_valid <= 1'b1;
                case (sc_op)
                    OP_MTHI: hi     <= sc_a;
                    OP_MTLO: lo     <= sc_a;
                    default: aluout <= alu_res;
                endcase
            end
            if (state == ST_DONE) begin
                out_valid <= 1'b1;
                if (op_mul) begin
                    {hi, lo} <= prod_fix;
                end else if (zdiv) begin
                    // quo still holds |a|, so re-signing it restores the original a.
                    hi  <= sgn_r ? -md_lo : md_lo;
                    lo  <= '1;
                    dbz <= 1'b1;
                end else begin
                    hi <= r_fix;
                    lo <= q_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: runs a 32-bit and a 16-bit instance side by side against
// a cycle-level behavioural model, plus hand-computed literal expectations.
module tb_alu_md;
    import alu_md_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  aluop;
    logic [31:0] a, b;
    logic [4:0]  s;

    logic        ov [2];
    logic        rdy[2];
    logic        dz [2];
    logic [31:0] ao [2];
    logic [31:0] ho [2];
    logic [31:0] lw [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint sx(input logic [63:0] x, input int w);
        longint t;
        t = longint'(x << (64 - w));
        return t >>> (64 - w);
    endfunction

    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [63:0] x, y,
                                            input int unsigned sh, input logic [63:0] h, l,
                                            input int w);
        logic [63:0] m, r;
        int unsigned vs;
        m  = (64'd1 << w) - 1;
        vs = int'(x & 64'(w - 1));
        case (op)
            OP_ADD:   r = x + y;
            OP_SUB:   r = x - y;
            OP_OR:    r = x | y;
            OP_SLT:   r = (sx(x, w) < sx(y, w)) ? 64'd1 : 64'd0;
            OP_SLL:   r = y << sh;
            OP_SRL:   r = y >> sh;
            OP_SRA:   r = 64'(sx(y, w) >>> sh);
            OP_SLLV:  r = y << vs;
            OP_SRLV:  r = y >> vs;
            OP_SRAV:  r = 64'(sx(y, w) >>> vs);
            OP_AND:   r = x & y;
            OP_XOR:   r = x ^ y;
            OP_NOR:   r = ~(x | y);
            OP_PASSA: r = x;
            OP_SLTU:  r = (x < y) ? 64'd1 : 64'd0;
            OP_MFHI:  r = h;
            OP_MFLO:  r = l;
            default:  r = 64'd0;
        endcase
        return r & m;
    endfunction

    function automatic void ref_md(input logic [4:0] op, input logic [63:0] x, y, input int w,
                                   output logic [63:0] h, output logic [63:0] l, output logic z);
        logic [63:0] m, pu;
        m = (64'd1 << w) - 1;
        z = 1'b0;
        if (op == OP_MULT || op == OP_MULTU) begin
            pu = (op == OP_MULT) ? 64'(sx(x, w) * sx(y, w)) : x * y;
            l  = pu & m;
            h  = (pu >> w) & m;
        end else if (y == 0) begin
            l = m;
            h = x;
            z = 1'b1;
        end else if (op == OP_DIV) begin
            l = 64'(sx(x, w) / sx(y, w)) & m;
            h = 64'(sx(x, w) % sx(y, w)) & m;
        end else begin
            l = (x / y) & m;
            h = (x % y) & m;
        end
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g
        localparam int W  = (gi == 0) ? 32 : 16;
        localparam int SW = $clog2(W);
        localparam logic [63:0] MSK = (64'd1 << W) - 1;

        logic [W-1:0] ao_w, ho_w, lo_w;

        alu_md #(.WIDTH(W), .SHAMT_W(SW)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (rdy[gi]),
            .aluop     (aluop),
            .a         (a[W-1:0]),
            .b         (b[W-1:0]),
            .s         (s[SW-1:0]),
            .out_valid (ov[gi]),
            .aluout    (ao_w),
            .hi        (ho_w),
            .lo        (lo_w),
            .dbz       (dz[gi])
        );

        assign ao[gi] = 32'(ao_w);
        assign ho[gi] = 32'(ho_w);
        assign lw[gi] = 32'(lo_w);

        logic [63:0] m_alu = '0, m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
        logic [63:0] sc_a = '0, sc_b = '0;
        logic        m_dbz = 1'b0, p_dbz = 1'b0, e_valid = 1'b0, sc_pend = 1'b0;
        logic [4:0]  sc_op = '0;
        int unsigned sc_s = 0;
        int          cnt = 0;

        // Model: single ops complete 1 cycle after accept, mul/div W+1, zero divide 2.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                m_alu = '0; m_hi = '0; m_lo = '0; m_dbz = 1'b0;
                e_valid = 1'b0; sc_pend = 1'b0; cnt = 0;
            end else begin
                e_valid = 1'b0;
                if (sc_pend) begin
                    sc_pend = 1'b0;
                    e_valid = 1'b1;
                    if (sc_op == OP_MTHI)      m_hi = sc_a;
                    else if (sc_op == OP_MTLO) m_lo = sc_a;
                    else m_alu = ref_alu(sc_op, sc_a, sc_b, sc_s, m_hi, m_lo, W);
                end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz; e_valid = 1'b1;
                    end
                end else if (in_valid) begin
                    m_dbz = 1'b0;
                    if (aluop >= OP_MULT && aluop <= OP_DIVU) begin
                        ref_md(aluop, a & MSK, b & MSK, W, p_hi, p_lo, p_dbz);
                        cnt = (aluop >= OP_DIV && (b & MSK) == 0) ? 2 : W + 1;
                    end else begin
                        sc_pend = 1'b1;
                        sc_op   = aluop;
                        sc_a    = a & MSK;
                        sc_b    = b & MSK;
                        sc_s    = int'(s) & (W - 1);
                    end
                end
            end
        end

        always @(negedge clk) begin
            chk($sformatf("w%0d out_valid", W), 64'(ov[gi]),  64'(e_valid));
            chk($sformatf("w%0d in_ready", W),  64'(rdy[gi]), 64'(cnt == 0));
            chk($sformatf("w%0d aluout", W),    64'(ao[gi]),  m_alu);
            chk($sformatf("w%0d hi", W),        64'(ho[gi]),  m_hi);
            chk($sformatf("w%0d lo", W),        64'(lw[gi]),  m_lo);
            chk($sformatf("w%0d dbz", W),       64'(dz[gi]),  64'(m_dbz));
        end
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] x, y, input logic [4:0] sh);
        aluop = op; a = x; b = y; s = sh; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int l0, output int l1);
        l0 = -1; l1 = -1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (ov[0] && l0 < 0) l0 = k;
            if (ov[1] && l1 < 0) l1 = k;
            if (l0 >= 0 && l1 >= 0) break;
        end
        if (l0 < 0 || l1 < 0) begin
            total++; bad++;
            $display("FAIL wait_done: out_valid not seen in 80 cycles (w32 %0d, w16 %0d)", l0, l1);
        end
    endtask

    task automatic run(input logic [4:0] op, input logic [31:0] x, y, input logic [4:0] sh,
                       output int l0, output int l1);
        issue(op, x, y, sh);
        wait_done(l0, l1);
    endtask

    typedef struct { logic [4:0] op; logic [31:0] x, y; logic [4:0] sh; } vec_t;
    vec_t singles[$] = '{
        '{OP_SUB,   32'h0,         32'h1,         5'd0},
        '{OP_ADD,   32'hFFFF_FFFF, 32'h1,         5'd0},
        '{OP_OR,    32'hF0F0_1234, 32'h0F0F_0001, 5'd0},
        '{OP_AND,   32'hF0F0_FFFF, 32'h3C3C_00F0, 5'd0},
        '{OP_XOR,   32'hAAAA_5555, 32'hFFFF_0F0F, 5'd0},
        '{OP_NOR,   32'h1234_0F00, 32'h0000_00F0, 5'd0},
        '{OP_PASSA, 32'hDEAD_BEEF, 32'h0,         5'd0},
        '{OP_SLL,   32'h0,         32'h1,         5'd31},
        '{OP_SRL,   32'h0,         32'h8000_8000, 5'd15},
        '{OP_SLLV,  32'd33,        32'h1,         5'd0},
        '{OP_SRLV,  32'd4,         32'hF000_F000, 5'd0},
        '{OP_SRAV,  32'd4,         32'h8000_8000, 5'd0},
        '{OP_SLT,   32'h7FFF_7FFF, 32'h8000_8000, 5'd0},
        '{5'h0F,    32'h1,         32'h1,         5'd0}
    };

    initial begin
        int l0, l1, seen;
        rst = 1'b1; in_valid = 1'b0; aluop = '0; a = '0; b = '0; s = '0;
        repeat (2) @(negedge clk);
        chk("reset aluout", 64'(ao[0]), 64'd0);
        chk("reset in_ready", 64'(rdy[0]), 64'd1);
        rst = 1'b0;

        run(OP_SRA, 32'h0, 32'h8000_0000, 5'd4, l0, l1);
        chk("sra4 w32", 64'(ao[0]), 64'hF800_0000);
        chk("sra latency w32", 64'(l0), 64'd1);
        chk("sra latency w16", 64'(l1), 64'd1);
        run(OP_SRA, 32'h0, 32'h8000_8000, 5'd0, l0, l1);
        chk("sra0 w32", 64'(ao[0]), 64'h8000_8000);
        chk("sra0 w16", 64'(ao[1]), 64'h8000);
        run(OP_SRA, 32'h0, 32'h8000_8000, 5'd4, l0, l1);
        chk("sra4 w16", 64'(ao[1]), 64'hF800);

        run(OP_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0, l0, l1);
        chk("slt w32", 64'(ao[0]), 64'd1);
        chk("slt w16", 64'(ao[1]), 64'd1);
        run(OP_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, l0, l1);
        chk("sltu w32", 64'(ao[0]), 64'd0);
        run(OP_ADD, 32'd3, 32'd4, 5'd0, l0, l1);
        chk("add w32", 64'(ao[0]), 64'd7);
        run(5'h1F, 32'd3, 32'd4, 5'd0, l0, l1);
        chk("undef w32", 64'(ao[0]), 64'd0);
        chk("undef latency", 64'(l0), 64'd1);

        foreach (singles[i]) issue(singles[i].op, singles[i].x, singles[i].y, singles[i].sh);
        wait_done(l0, l1);
        repeat (2) @(negedge clk);

        run(OP_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0, l0, l1);
        chk("mult hi w32", 64'(ho[0]), 64'hFFFF_FFFF);
        chk("mult lo w32", 64'(lw[0]), 64'hFFFF_FFEB);
        chk("mult lo w16", 64'(lw[1]), 64'hFFEB);
        chk("mult latency w32", 64'(l0), 64'd33);
        chk("mult latency w16", 64'(l1), 64'd17);
        run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, l0, l1);
        chk("multu hi w32", 64'(ho[0]), 64'hFFFF_FFFE);
        chk("multu lo w32", 64'(lw[0]), 64'h1);
        chk("multu hi w16", 64'(ho[1]), 64'hFFFE);

        run(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, l0, l1);
        chk("div lo w32", 64'(lw[0]), 64'hFFFF_FFFD);
        chk("div hi w32", 64'(ho[0]), 64'hFFFF_FFFF);
        chk("div hi w16", 64'(ho[1]), 64'hFFFF);
        run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, l0, l1);
        chk("div min lo w32", 64'(lw[0]), 64'h8000_0000);
        chk("div min hi w32", 64'(ho[0]), 64'd0);
        run(OP_DIVU, 32'd7, 32'd0, 5'd0, l0, l1);
        chk("divu0 lo w32", 64'(lw[0]), 64'hFFFF_FFFF);
        chk("divu0 hi w32", 64'(ho[0]), 64'd7);
        chk("divu0 dbz w32", 64'(dz[0]), 64'd1);
        chk("divu0 latency w32", 64'(l0), 64'd2);
        chk("divu0 latency w16", 64'(l1), 64'd2);
        run(OP_DIV, 32'hFFFF_FFF9, 32'd0, 5'd0, l0, l1);
        chk("div0 hi w32", 64'(ho[0]), 64'hFFFF_FFF9);
        run(OP_PASSA, 32'd9, 32'd0, 5'd0, l0, l1);
        chk("dbz cleared", 64'(dz[0]), 64'd0);

        issue(OP_MULT, 32'd5, 32'd6, 5'd0);
        repeat (3) @(negedge clk);
        issue(OP_ADD, 32'd100, 32'd200, 5'd0);
        wait_done(l0, l1);
        chk("busy ignore aluout", 64'(ao[0]), 64'd9);
        chk("busy mult lo", 64'(lw[0]), 64'd30);
        issue(OP_MTLO, 32'd5, 32'd0, 5'd0);
        run(OP_MFLO, 32'd0, 32'd0, 5'd0, l0, l1);
        chk("mflo w32", 64'(ao[0]), 64'd5);
        chk("mflo w16", 64'(ao[1]), 64'd5);

        issue(OP_DIV, 32'd100, 32'd7, 5'd0);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst hi w32", 64'(ho[0]), 64'd0);
        chk("rst lo w16", 64'(lw[1]), 64'd0);
        chk("rst in_ready w32", 64'(rdy[0]), 64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov[0] || ov[1]) seen++;
        end
        chk("no out_valid after rst", 64'(seen), 64'd0);
        run(OP_SUB, 32'd10, 32'd3, 5'd0, l0, l1);
        chk("post-rst sub", 64'(ao[0]), 64'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
